// File: rtl/cmac_pkg.sv
// Shared definitions for the CMAC message driver.
//   state_t   : driver FSM states
//   BLK_W     : AES block width (bits)
//   WORD_W    : message stream word width (bits)
//   LEN_FULL  : Last_Block_Len code for a completely filled block
//   byte_mask : keeps the first n bytes (MSB first) of a stream word
package cmac_pkg;

    localparam int         BLK_W    = 128;
    localparam int         WORD_W   = 32;
    localparam logic [7:0] LEN_FULL = 8'd128;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LD,
        KEY_WAIT,
        GAP,
        FILL,
        BLK_LD,
        BLK_WAIT,
        TAG_OUT
    } state_t;

    function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nbytes);
        case (nbytes)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hFF00_0000;
            3'd2:    byte_mask = 32'hFFFF_0000;
            3'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/cmac_blk_packer.sv
// Packs 32-bit message words into a 128-bit block for the CMAC core.
// Ports:
//   CLK, Rst_n      clock / asynchronous active-low reset
//   i_clr           restart at word slot 0 (new message)
//   i_accept        a word is accepted this cycle
//   i_data          message word (slot 0 lands in bits [127:96])
//   i_last, i_bytes final-word flag and its valid byte count (0..4)
//   o_blk_done      this accept completes a block (4th word or last word)
//   o_is_last       this accept completes the last block
//   o_block         packed block, unfilled bytes zero
//   o_last_block    registered Last_Block for the completed block
//   o_len           registered Last_Block_Len (bits) for the completed block
module cmac_blk_packer
    import cmac_pkg::*;
(
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              i_clr,
    input  logic              i_accept,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_last,
    input  logic [2:0]        i_bytes,
    output logic              o_blk_done,
    output logic              o_is_last,
    output logic [BLK_W-1:0]  o_block,
    output logic              o_last_block,
    output logic [7:0]        o_len
);

    logic [1:0]        r_slot;
    logic [BLK_W-1:0]  r_block;
    logic              r_last_block;
    logic [7:0]        r_len;

    logic [2:0]        w_nbytes;
    logic [WORD_W-1:0] w_word;
    logic [4:0]        w_blk_bytes;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        w_nbytes    = (!i_last || i_bytes > 3'd4) ? 3'd4 : i_bytes;
        w_word      = i_data & byte_mask(w_nbytes);
        w_blk_bytes = {1'b0, r_slot, 2'b00} + {2'b00, w_nbytes};
    end

    assign o_blk_done   = i_accept && (i_last || r_slot == 2'd3);
    assign o_is_last    = i_accept && i_last;
    assign o_block      = r_block;
    assign o_last_block = r_last_block;
    assign o_len        = r_len;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_slot       <= '0;
            r_block      <= '0;
            r_last_block <= 1'b0;
            r_len        <= '0;
        end else if (i_clr) begin
            r_slot <= '0;
        end else if (i_accept) begin
            // Writing slot 0 clears the rest, so stale data from the previous
            // block can never leak into a short final block.
            case (r_slot)
                2'd0:    r_block <= {w_word, {(BLK_W-WORD_W){1'b0}}};
                2'd1:    r_block[95:64] <= w_word;
                2'd2:    r_block[63:32] <= w_word;
                default: r_block[31:0]  <= w_word;
            endcase
            if (o_blk_done) begin
                r_slot       <= '0;
                r_last_block <= i_last;
                r_len        <= i_last ? {w_blk_bytes, 3'b000} : LEN_FULL;
            end else begin
                r_slot <= r_slot + 2'd1;
            end
        end
    end

endmodule

// File: rtl/cmac_msg_driver.sv
// Initiator-side driver for the CMAC-AES128 core handshake.
// Accepts a key (plus optional expected tag), packs a 32-bit word stream into
// 128-bit blocks, sequences key load / block loads / last block into the core
// and returns the tag on a valid/ready port, optionally compared to exp_tag.
// Ports:
//   key_valid/key_ready/key/vrfy_en/exp_tag  key channel (accepted in IDLE)
//   s_valid/s_ready/s_data/s_last/s_bytes    message word stream
//   core_*                                   CMAC core handshake
//   tag_valid/tag_ready/tag/match            tag result channel
//   err                                      sticky Done timeout flag
module cmac_msg_driver
    import cmac_pkg::*;
#(
    parameter int LD_GAP      = 2,   // >= 1 idle cycles after each core_Done
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [BLK_W-1:0]  key,
    input  logic              vrfy_en,
    input  logic [BLK_W-1:0]  exp_tag,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    input  logic [2:0]        s_bytes,
    output logic              core_ld_Key,
    output logic              core_ld_Block,
    output logic              core_Last_Block,
    output logic [7:0]        core_Last_Block_Len,
    output logic [BLK_W-1:0]  core_KEY,
    output logic [BLK_W-1:0]  core_TextIn,
    input  logic              core_Done,
    input  logic [BLK_W-1:0]  core_TextOut,
    output logic              tag_valid,
    input  logic              tag_ready,
    output logic [BLK_W-1:0]  tag,
    output logic              match,
    output logic              err
);

    localparam int               TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int               GAP_W    = (LD_GAP > 1) ? $clog2(LD_GAP) : 1;
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LD_GAP - 1);

    state_t             r_state;
    state_t             r_ret;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [BLK_W-1:0]   r_key;
    logic               r_vrfy;
    logic [BLK_W-1:0]   r_exp_tag;
    logic [BLK_W-1:0]   r_tag;
    logic               r_match;
    logic               r_err;
    logic               r_key_ready;
    logic               r_s_ready;
    logic               r_ld_key;
    logic               r_ld_blk;
    logic               r_tag_valid;
    logic               r_blk_last;

    logic               w_key_acc;
    logic               w_s_acc;
    logic               w_blk_done;
    logic               w_is_last;
    logic               w_to_expired;

    assign w_key_acc    = (r_state == IDLE) && key_valid && r_key_ready;
    assign w_s_acc      = (r_state == FILL) && s_valid && r_s_ready;
    // The counter is 1 in the first wait cycle, so expiry fires after
    // TIMEOUT_CYC full cycles without core_Done.
    assign w_to_expired = (r_to_cnt == TO_MAX);

    cmac_blk_packer u_packer (
        .CLK          (CLK),
        .Rst_n        (Rst_n),
        .i_clr        (w_key_acc),
        .i_accept     (w_s_acc),
        .i_data       (s_data),
        .i_last       (s_last),
        .i_bytes      (s_bytes),
        .o_blk_done   (w_blk_done),
        .o_is_last    (w_is_last),
        .o_block      (core_TextIn),
        .o_last_block (core_Last_Block),
        .o_len        (core_Last_Block_Len)
    );

    assign key_ready     = r_key_ready;
    assign s_ready       = r_s_ready;
    assign core_ld_Key   = r_ld_key;
    assign core_ld_Block = r_ld_blk;
    assign core_KEY      = r_key;
    assign tag_valid     = r_tag_valid;
    assign tag           = r_tag;
    assign match         = r_match;
    assign err           = r_err;

    // NOTE: wide data registers (key, tag) are reset as well because their
    // reset value is architecturally visible on the outputs.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_ret       <= IDLE;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
            r_key       <= '0;
            r_vrfy      <= 1'b0;
            r_exp_tag   <= '0;
            r_tag       <= '0;
            r_match     <= 1'b0;
            r_err       <= 1'b0;
            r_key_ready <= 1'b0;
            r_s_ready   <= 1'b0;
            r_ld_key    <= 1'b0;
            r_ld_blk    <= 1'b0;
            r_tag_valid <= 1'b0;
            r_blk_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_key_acc) begin
                        r_key       <= key;
                        r_vrfy      <= vrfy_en;
                        r_exp_tag   <= exp_tag;
                        r_err       <= 1'b0;
                        r_key_ready <= 1'b0;
                        r_ld_key    <= 1'b1;
                        r_state     <= KEY_LD;
                    end else begin
                        r_key_ready <= 1'b1;
                    end
                end
                KEY_LD: begin
                    r_ld_key <= 1'b0;
                    r_to_cnt <= TO_W'(1);
                    r_state  <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    if (core_Done) begin
                        r_ret     <= FILL;
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end else if (w_to_expired) begin
                        r_err       <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= r_ret;
                        if (r_ret == FILL) r_s_ready   <= 1'b1;
                        else               r_key_ready <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                FILL: begin
                    if (w_blk_done) begin
                        r_s_ready  <= 1'b0;
                        r_ld_blk   <= 1'b1;
                        r_blk_last <= w_is_last;
                        r_state    <= BLK_LD;
                    end
                end
                BLK_LD: begin
                    r_ld_blk <= 1'b0;
                    r_to_cnt <= TO_W'(1);
                    r_state  <= BLK_WAIT;
                end
                BLK_WAIT: begin
                    if (core_Done) begin
                        if (r_blk_last) begin
                            r_tag       <= core_TextOut;
                            r_match     <= r_vrfy && (core_TextOut == r_exp_tag);
                            r_tag_valid <= 1'b1;
                            r_state     <= TAG_OUT;
                        end else begin
                            r_ret     <= FILL;
                            r_gap_cnt <= '0;
                            r_state   <= GAP;
                        end
                    end else if (w_to_expired) begin
                        r_err       <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                TAG_OUT: begin
                    if (tag_ready) begin
                        r_tag_valid <= 1'b0;
                        r_ret       <= IDLE;
                        r_gap_cnt   <= '0;
                        r_state     <= GAP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmac_msg_driver.sv
// Directed self-checking bench for cmac_msg_driver. A small core stand-in
// answers each load pulse with core_Done after a fixed latency and returns a
// bench-chosen tag for the last block; the bench checks the blocks presented
// to the core, the hold rules, the tag channel, verify mode, timeout and reset.
module tb_cmac_msg_driver;
    import cmac_pkg::*;

    localparam int TIMEOUT_CYC = 64;
    localparam int DONE_LAT    = 3;
    localparam int WAIT_MAX    = 300;

    localparam logic [127:0] K      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T_EMP  = 128'hbb1d6929e95937287fa37d129b756746;
    localparam logic [127:0] T_16   = 128'h070a16b46b4d4144f79bdd9dd04a287c;
    localparam logic [127:0] T_40   = 128'hdfa66747de9ae63030ca32611497c827;
    localparam logic [127:0] T_PART = 128'h0123456789abcdeffedcba9876543210;

    logic         CLK = 1'b0;
    logic         Rst_n;
    logic         key_valid, key_ready, vrfy_en;
    logic [127:0] key, exp_tag;
    logic         s_valid, s_ready, s_last;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         core_ld_Key, core_ld_Block, core_Last_Block, core_Done;
    logic [7:0]   core_Last_Block_Len;
    logic [127:0] core_KEY, core_TextIn, core_TextOut;
    logic         tag_valid, tag_ready, match, err;
    logic [127:0] tag;

    typedef struct {
        logic [127:0] txt;
        logic         last;
        logic [7:0]   len;
        logic         held;
    } blk_rec_t;

    blk_rec_t     blk_q[$];
    int           key_loads = 0;
    logic [127:0] key_seen  = '0;
    logic         core_mute = 1'b0;
    logic [127:0] model_tag = '0;
    logic [31:0]  msg [0:15];
    int           passed = 0, failed = 0, total = 0;

    always #5 CLK = ~CLK;

    cmac_msg_driver #(.LD_GAP(2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .Rst_n(Rst_n),
        .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .vrfy_en(vrfy_en), .exp_tag(exp_tag),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_bytes(s_bytes),
        .core_ld_Key(core_ld_Key), .core_ld_Block(core_ld_Block),
        .core_Last_Block(core_Last_Block), .core_Last_Block_Len(core_Last_Block_Len),
        .core_KEY(core_KEY), .core_TextIn(core_TextIn),
        .core_Done(core_Done), .core_TextOut(core_TextOut),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag),
        .match(match), .err(err)
    );

    // Core stand-in: Done DONE_LAT cycles after each load pulse.
    initial begin
        blk_rec_t rec;
        core_Done    = 1'b0;
        core_TextOut = '0;
        forever begin
            @(posedge CLK); #1;
            if (core_ld_Key && !core_mute) begin
                key_loads++;
                key_seen = core_KEY;
                repeat (DONE_LAT - 1) @(posedge CLK);
                #1;
                core_Done    = 1'b1;
                core_TextOut = ~model_tag;
                @(posedge CLK); #1;
                core_Done = 1'b0;
            end else if (core_ld_Block && !core_mute) begin
                rec.txt  = core_TextIn;
                rec.last = core_Last_Block;
                rec.len  = core_Last_Block_Len;
                repeat (DONE_LAT - 1) @(posedge CLK);
                #1;
                rec.held = (core_TextIn === rec.txt) && (core_Last_Block === rec.last) &&
                           (core_Last_Block_Len === rec.len);
                blk_q.push_back(rec);
                core_Done    = 1'b1;
                core_TextOut = rec.last ? model_tag : ~model_tag;
                @(posedge CLK); #1;
                core_Done = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic do_key(input logic [127:0] k, input logic v, input logic [127:0] e);
        int n;
        @(negedge CLK);
        key_valid = 1'b1; key = k; vrfy_en = v; exp_tag = e;
        n = 0;
        while (!key_ready && n < WAIT_MAX) begin @(negedge CLK); n++; end
        if (n == WAIT_MAX) check("key_ready_wait", 128'(key_ready), 128'd1);
        @(posedge CLK); #1;
        key_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
        int n;
        @(negedge CLK);
        s_valid = 1'b1; s_data = d; s_last = l; s_bytes = b;
        n = 0;
        while (!s_ready && n < WAIT_MAX) begin @(negedge CLK); n++; end
        if (n == WAIT_MAX) check("s_ready_wait", 128'(s_ready), 128'd1);
        @(posedge CLK); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_msg(input int nwords, input logic [2:0] last_bytes);
        for (int i = 0; i < nwords; i++)
            send_word(msg[i], (i == nwords - 1), last_bytes);
    endtask

    task automatic get_tag(input string name, input logic [127:0] et, input logic em,
                           input logic hold);
        int n;
        n = 0;
        @(negedge CLK);
        while (!tag_valid && n < WAIT_MAX) begin @(negedge CLK); n++; end
        check({name, "_tag_valid"}, 128'(tag_valid), 128'd1);
        check({name, "_tag"}, tag, et);
        check({name, "_match"}, 128'(match), 128'(em));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge CLK);
                check({name, "_hold_valid"}, 128'(tag_valid), 128'd1);
                check({name, "_hold_tag"}, tag, et);
            end
        end
        tag_ready = 1'b1;
        @(posedge CLK); #1;
        tag_ready = 1'b0;
        check({name, "_tag_drop"}, 128'(tag_valid), 128'd0);
    endtask

    task automatic check_blk(input string name, input logic [127:0] txt, input logic last,
                             input logic [7:0] len);
        blk_rec_t r;
        if (blk_q.size() == 0) return;
        r = blk_q.pop_front();
        check({name, "_text"}, r.txt, txt);
        check({name, "_last"}, 128'(r.last), 128'(last));
        if (last) check({name, "_len"}, 128'(r.len), 128'(len));
        check({name, "_held"}, 128'(r.held), 128'd1);
    endtask

    task automatic check_zero(input string name);
        check({name, "_key_ready"}, 128'(key_ready), 128'd0);
        check({name, "_s_ready"}, 128'(s_ready), 128'd0);
        check({name, "_ld"}, 128'({core_ld_Key, core_ld_Block, core_Last_Block}), 128'd0);
        check({name, "_len"}, 128'(core_Last_Block_Len), 128'd0);
        check({name, "_key"}, core_KEY, 128'd0);
        check({name, "_textin"}, core_TextIn, 128'd0);
        check({name, "_tagflags"}, 128'({tag_valid, match, err}), 128'd0);
        check({name, "_tag"}, tag, 128'd0);
    endtask

    initial begin
        int n;
        logic [127:0] bad_tag;
        Rst_n = 1'b0;
        key_valid = 1'b0; key = '0; vrfy_en = 1'b0; exp_tag = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0;
        tag_ready = 1'b0;
        msg[0] = 32'h6bc1bee2; msg[1] = 32'h2e409f96; msg[2] = 32'he93d7e11;
        msg[3] = 32'h7393172a; msg[4] = 32'hae2d8a57; msg[5] = 32'h1e03ac9c;
        msg[6] = 32'h9eb76fac; msg[7] = 32'h45af8e51; msg[8] = 32'h30c81c46;
        msg[9] = 32'ha35ce411;
        for (int i = 10; i < 16; i++) msg[i] = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        check_zero("reset");
        Rst_n = 1'b1;

        // Empty message: junk data must be masked to an all-zero block
        model_tag = T_EMP;
        do_key(K, 1'b0, '0);
        send_word(32'hdeadbeef, 1'b1, 3'd0);
        get_tag("empty", T_EMP, 1'b0, 1'b0);
        check("empty_key_loads", 128'(key_loads), 128'd1);
        check("empty_key_seen", key_seen, K);
        check("empty_nblk", 128'(blk_q.size()), 128'd1);
        check_blk("empty_b0", 128'd0, 1'b1, 8'd0);

        // Exactly one full block: Len = 128
        model_tag = T_16;
        do_key(K, 1'b0, '0);
        run_msg(4, 3'd4);
        get_tag("m16", T_16, 1'b0, 1'b0);
        check("m16_nblk", 128'(blk_q.size()), 128'd1);
        check_blk("m16_b0", 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 8'h80);

        // 40-byte message: two intermediate blocks, last block Len = 64
        model_tag = T_40;
        do_key(K, 1'b0, '0);
        run_msg(10, 3'd4);
        get_tag("m40", T_40, 1'b0, 1'b0);
        check("m40_nblk", 128'(blk_q.size()), 128'd3);
        check_blk("m40_b0", 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 8'd0);
        check_blk("m40_b1", 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, 8'd0);
        check_blk("m40_b2", 128'h30c81c46a35ce411_0000000000000000, 1'b1, 8'd64);
        check("m40_key", core_KEY, K);

        // 5-byte message: bytes beyond s_bytes in the last word are zeroed
        model_tag = T_PART;
        do_key(K, 1'b0, '0);
        run_msg(2, 3'd1);
        get_tag("m5", T_PART, 1'b0, 1'b0);
        check("m5_nblk", 128'(blk_q.size()), 128'd1);
        check_blk("m5_b0", 128'h6bc1bee22e000000_0000000000000000, 1'b1, 8'd40);

        // Verify mode: match, mismatch, disabled; tag held while not ready
        model_tag = T_16;
        do_key(K, 1'b1, T_16);
        run_msg(4, 3'd4);
        get_tag("vrfy_ok", T_16, 1'b1, 1'b1);
        bad_tag = T_16 ^ (128'd1 << 37);
        do_key(K, 1'b1, bad_tag);
        run_msg(4, 3'd4);
        get_tag("vrfy_bad", T_16, 1'b0, 1'b0);
        do_key(K, 1'b0, T_16);
        run_msg(4, 3'd4);
        get_tag("vrfy_off", T_16, 1'b0, 1'b0);
        blk_q.delete();

        // Timeout: core never answers the block load
        do_key(K, 1'b0, '0);
        n = 0;
        while (!s_ready && n < WAIT_MAX) begin @(negedge CLK); n++; end
        core_mute = 1'b1;
        run_msg(4, 3'd4);
        n = 0;
        while (!core_ld_Block && n < 20) begin @(posedge CLK); #1; n++; end
        check("to_pulse", 128'(core_ld_Block), 128'd1);
        repeat (TIMEOUT_CYC) @(posedge CLK);
        #1;
        check("to_err_before", 128'(err), 128'd0);
        @(posedge CLK); #1;
        check("to_err", 128'(err), 128'd1);
        check("to_key_ready", 128'(key_ready), 128'd1);
        check("to_s_ready", 128'(s_ready), 128'd0);
        repeat (5) @(negedge CLK);
        check("to_s_ready_later", 128'(s_ready), 128'd0);
        check("to_err_sticky", 128'(err), 128'd1);
        core_mute = 1'b0;
        model_tag = T_16;
        do_key(K, 1'b0, '0);
        check("to_err_clear", 128'(err), 128'd0);
        run_msg(4, 3'd4);
        get_tag("to_recover", T_16, 1'b0, 1'b0);
        blk_q.delete();

        // Asynchronous reset during BLK_WAIT, then a clean message
        do_key(K, 1'b0, '0);
        run_msg(4, 3'd4);
        @(posedge CLK);
        @(negedge CLK);
        Rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge CLK); #1;
        check_zero("rst_edge");
        @(negedge CLK);
        Rst_n = 1'b1;
        repeat (6) @(negedge CLK);
        blk_q.delete();
        model_tag = T_16;
        do_key(K, 1'b0, '0);
        run_msg(4, 3'd4);
        get_tag("post_rst", T_16, 1'b0, 1'b0);
        check("post_rst_nblk", 128'(blk_q.size()), 128'd1);
        check_blk("post_rst_b0", 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 8'h80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cmac_msg_driver.md
Name: cmac_msg_driver

Overview:
Initiator-side driver for the CMAC-AES128 core handshake (ld_Key / ld_Block / Last_Block / Last_Block_Len / Done).
- Accepts a key and a 32-bit word message stream, packs words into 128-bit blocks, and sequences key load, the intermediate blocks and the last block into the core.
- Returns the 128-bit tag on a valid/ready port.
- Optionally compares the tag against an expected tag (verify mode).

Parameters:
- LD_GAP, 2, idle cycles inserted after each core_Done before the next core load pulse (covers the core's registered next-state lag).
- TIMEOUT_CYC, 64, maximum cycles waiting for core_Done before aborting; counter width is clog2(TIMEOUT_CYC+1).

Ports:
- CLK  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key offered
- key_ready  out  1  key accepted when key_valid & key_ready
- key  in  128  AES-128 key
- vrfy_en  in  1  sampled with key; 1 = compare tag against exp_tag
- exp_tag  in  128  expected tag, sampled with key
- s_valid  in  1  message word valid
- s_ready  out  1  message word accepted when s_valid & s_ready
- s_data  in  32  message word; first word of a block maps to bits [127:96]
- s_last  in  1  final word of the message
- s_bytes  in  3  valid bytes in the final word (1..4); 0 with s_last = empty message; ignored when s_last=0
- core_ld_Key  out  1  one-cycle key-load pulse
- core_ld_Block  out  1  one-cycle block-load pulse
- core_Last_Block  out  1  current block is the last block
- core_Last_Block_Len  out  8  valid bits in the last block (0..128; 128 = 8'h80)
- core_KEY  out  128  key register
- core_TextIn  out  128  block register
- core_Done  in  1  core completion strobe
- core_TextOut  in  128  core result
- tag_valid  out  1  tag available
- tag_ready  in  1  tag consumed when tag_valid & tag_ready
- tag  out  128  CMAC tag
- match  out  1  tag == exp_tag (forced 0 when vrfy_en=0); valid with tag_valid
- err  out  1  sticky timeout flag; cleared by the next key acceptance

Behaviour:
- Reset: all outputs 0; key, block, tag and exp_tag registers 0; FSM in IDLE; byte counter 0.
- FSM states and transitions:
  - IDLE: key_ready=1. On key handshake, latch key, vrfy_en and exp_tag; clear err; go to KEY_LD.
  - KEY_LD: core_ld_Key=1 for exactly one cycle; go to KEY_WAIT.
  - KEY_WAIT: wait core_Done; go to GAP, then FILL.
  - GAP: count LD_GAP cycles, then go to the return state.
  - FILL: s_ready=1. Each accepted word is written into word slot 0..3.
    - Block complete when the 4th word is accepted or s_last is accepted.
    - If s_last=0, go to BLK_LD with Last_Block=0.
    - If s_last=1, set Last_Block=1 and Len=8*(4*slot+s_bytes); zero unfilled bytes, including bytes beyond s_bytes in the final word; go to BLK_LD.
  - BLK_LD: core_ld_Block=1 for one cycle; go to BLK_WAIT.
  - BLK_WAIT: wait core_Done.
    - Intermediate block: go to GAP, then FILL.
    - Last block: capture core_TextOut into tag, compute match, go to TAG_OUT.
  - TAG_OUT: tag_valid=1 until tag_ready; then go to GAP, then IDLE.
- Hold rules:
  - core_TextIn, core_Last_Block and core_Last_Block_Len are held stable from the load pulse until core_Done, because the core uses them combinationally.
  - core_KEY is held for the whole message.
- Empty message: s_last with s_bytes=0 in slot 0 gives an all-zero block, Last_Block=1, Len=0.
- A message of exactly 16n bytes sends its final full block with Len=128 (k1 path).
- Done-wait latency: timeout counter runs only in KEY_WAIT and BLK_WAIT, restarts at each load pulse, and is compared against TIMEOUT_CYC.
  - On expiry: set err, drop the message, go to IDLE.
  - s_ready stays 0 until a new key is loaded; the upstream must restart the message.
- core_Done outside the WAIT states is ignored.
- s_valid is not accepted outside FILL; key_valid is not accepted outside IDLE.
- Asynchronous reset mid-operation returns to IDLE immediately; any in-flight tag is lost.

Decomposition:
- Shared package cmac_pkg:
  - FSM state enum (IDLE, KEY_LD, KEY_WAIT, GAP, FILL, BLK_LD, BLK_WAIT, TAG_OUT).
  - BLK_W=128, WORD_W=32, LEN_FULL=8'd128.
- Sub-module cmac_blk_packer: word slot counter, byte masking and Last_Block_Len computation; output is block-complete / is-last flags.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, empty message -> one block, Last_Block=1, Len=0, TextIn=0; tag bb1d6929e95937287fa37d129b756746.
- Same key, 4 words 6bc1bee2 2e409f96 e93d7e11 7393172a -> Len=8'h80; tag 070a16b46b4d4144f79bdd9dd04a287c.
- Same key, 40-byte message (10 words) -> two blocks with Last_Block=0, third block Len=64 with bytes 8..15 zero; tag dfa66747de9ae63030ca32611497c827.
- vrfy_en=1 with correct exp_tag -> match=1; single bit flipped -> match=0; tag_ready held low 5 cycles -> tag_valid/tag stable.
- core_Done never asserted -> err=1 at TIMEOUT_CYC+1 cycles after the pulse, FSM in IDLE, key_ready=1.
- Rst_n pulsed during BLK_WAIT -> all outputs 0 next edge; new key plus message afterwards produce the correct tag.
